mem_access: RTL and testbench
=============================

# mem_access

Load/store unit for the MEM stage of the five-stage pipeline. It sits directly upstream of the MEM/WB pipeline register and turns the current MEM-stage memory operation into a request/acknowledge transaction on the data-memory bus. Load data is aligned and extended, then presented as `mem_MEMOUT`. While a transaction is outstanding the unit raises `mem_stall` so the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM.

## Interface
- `WAIT_MAX`, default 255: maximum number of BUSY cycles without `dmem_ack` before the access is aborted. Legal range is 1..65535.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_MemRead` in 1: load in MEM stage.
- `mem_MemWrite` in 1: store in MEM stage. Never asserted together with `mem_MemRead`.
- `mem_size` in 2: access size. 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `mem_signext` in 1: sign-extend byte/half loads when 1, zero-extend when 0.
- `mem_ALUOUT` in 32: effective byte address.
- `mem_WriteData` in 32: store data, right-justified.
- `mem_MEMOUT` out 32: registered, aligned and extended load result, consumed by MEM/WB.
- `mem_stall` out 1: combinational freeze request to the hazard unit.
- `mem_misalign` out 1: combinational alignment-exception flag.
- `mem_buserr` out 1: registered, one-cycle timeout flag.
- `dmem_req` out 1: registered bus request.
- `dmem_we` out 1: registered write enable.
- `dmem_addr` out 32: registered word address, bits [1:0] forced to 00.
- `dmem_be` out 4: registered byte enables; bit i covers `dmem_wdata[8i+7:8i]`.
- `dmem_wdata` out 32: registered, lane-replicated store data.
- `dmem_rdata` in 32: read word, valid when `dmem_ack` = 1.
- `dmem_ack` in 1: one-cycle completion pulse from memory.

## Operation
- Definitions:
  - access = `mem_MemRead` | `mem_MemWrite`.
  - A half access is misaligned if addr[0] = 1.
  - A word access is misaligned if addr[1:0] ≠ 00.
- FSM states: IDLE, BUSY, DONE.
- IDLE, access and aligned:
  - Latch `dmem_addr`, `dmem_we`, `dmem_be`, `dmem_wdata`; latch size, signext and addr[1:0] internally.
  - Set `dmem_req` = 1 and go to BUSY.
  - Clear the wait counter.
- IDLE, access but misaligned:
  - `mem_misalign` = 1 in the same cycle.
  - No request, no stall, `mem_MEMOUT` unchanged; stay in IDLE.
- IDLE, no access: stay in IDLE, outputs hold.
- BUSY, `dmem_ack` = 1:
  - Clear `dmem_req`.
  - For a load, `mem_MEMOUT` ← formatted `dmem_rdata`; for a store, `mem_MEMOUT` holds.
  - Go to DONE.
- BUSY, no ack:
  - Wait counter increments.
  - When the counter reaches `WAIT_MAX`, clear `dmem_req`, set `mem_buserr` for the next cycle, set `mem_MEMOUT` to 0 for a load, and go to DONE.
- DONE: go unconditionally to IDLE. `mem_buserr` clears after DONE.
- `mem_stall` = (IDLE & access & aligned) | BUSY.
  - `mem_stall` is 0 in DONE, so the pipeline advances on the DONE edge and MEM/WB captures `mem_MEMOUT`.
  - `mem_stall` is 0 while `rst` = 1.
- `dmem_ack` outside BUSY is ignored.
- Store lanes:
  - Byte: `dmem_be` = 0001 << addr[1:0]; `dmem_wdata` = the byte replicated ×4.
  - Half: `dmem_be` = addr[1] ? 1100 : 0011; `dmem_wdata` = the half replicated ×2.
  - Word: `dmem_be` = 1111.
- Load lanes (little-endian):
  - Byte: byte at lane addr[1:0].
  - Half: bits [31:16] if addr[1] = 1, else [15:0].
  - Extension per the latched signext.
  - Load requests drive `dmem_be` = 1111.

## Timing
- Reset (asynchronous): state IDLE, counter 0, and every registered output is 0: `mem_MEMOUT`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `mem_buserr`.
- Reset during BUSY aborts the transaction immediately. A late `dmem_ack` after reset is ignored.
- Minimum access, with ack in the first BUSY cycle:
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: BUSY, req = 1, ack = 1.
  - Cycle 2: DONE, stall = 0, `mem_MEMOUT` valid.
  - Total: 3 cycles, of which 2 are stall cycles.
- With N wait cycles before ack: 3 + N cycles.
- `dmem_req` and all bus fields stay stable from the first BUSY cycle until the cycle of ack or timeout.
- Back-to-back memory operations: the next operation is seen in IDLE the cycle after DONE, so there is no overlap between operations.
- `mem_MEMOUT` holds its value until the next load completes or reset.

## Test plan
- Reset with no access → all outputs 0, `mem_stall` = 0. Assert `rst` mid-BUSY → `dmem_req` drops asynchronously; a subsequent ack is ignored.
- Aligned word load at 0x100, memory acks in the first BUSY cycle with 0x8899AABB → stall high for exactly 2 cycles; `dmem_addr` = 0x100, `dmem_be` = 1111; `mem_MEMOUT` = 0x8899AABB in DONE.
- Byte loads from rdata 0x8899AABB at addr[1:0] = 3:
  - signext = 1 → 0xFFFFFF88.
  - signext = 0 → 0x00000088.
- Half load at addr[1:0] = 2 with signext = 1 → 0xFFFF8899.
- Byte store of 0x5A at 0x203 → `dmem_be` = 1000, `dmem_wdata` = 0x5A5A5A5A, `dmem_we` = 1, `dmem_addr` = 0x200; `mem_MEMOUT` unchanged.
- Half store at 0x202 → `dmem_be` = 1100.
- Word load at 0x102 → `mem_misalign` = 1 that cycle, no `dmem_req`, no stall.
- `WAIT_MAX` = 4 with ack never asserted → `dmem_req` high 4 cycles, then `mem_buserr` pulses 1 cycle and `mem_MEMOUT` = 0.
- Two back-to-back loads with 2 wait cycles each → 5-cycle spacing; each DONE cycle carries the correct data.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM-stage load/store unit and data memory.
// The unit issues a request and the memory answers with a one-cycle ack.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  // Load/store unit side
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  // Memory side
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store unit: turns the current memory operation into a
// req/ack bus transaction, stalls the pipeline while it is outstanding,
// aligns/extends load data and aborts accesses that wait too long.
module mem_access #(
  parameter int WAIT_MAX = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_MemRead,
  input  logic               mem_MemWrite,
  input  logic [1:0]         mem_size,
  input  logic               mem_signext,
  input  logic [31:0]        mem_ALUOUT,
  input  logic [31:0]        mem_WriteData,
  output logic [31:0]        mem_MEMOUT,
  output logic               mem_stall,
  output logic               mem_misalign,
  output logic               mem_buserr,
  mem_access_if.master       dmem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] memout_q, memout_d;
  logic        buserr_q, buserr_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        access;
  logic        misaligned;
  logic        start;
  logic        timeout;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign access     = mem_MemRead | mem_MemWrite;
  // Size 11 behaves as a word access.
  assign misaligned = (mem_size == 2'b01) ? mem_ALUOUT[0] :
                      (mem_size[1]        ? (mem_ALUOUT[1:0] != 2'b00) : 1'b0);
  assign start      = (state_q == IDLE) & access & ~misaligned;
  // The counter saturating at WAIT_MAX-1 means WAIT_MAX BUSY cycles have elapsed.
  assign timeout    = (state_q == BUSY) & ~dmem.dmem_ack &
                      (cnt_q == 16'(WAIT_MAX - 1));

  assign mem_misalign = (state_q == IDLE) & access & misaligned;
  assign mem_stall    = ~rst & (start | (state_q == BUSY));
  assign mem_MEMOUT   = memout_q;
  assign mem_buserr   = buserr_q;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  // Store lane steering: byte enables and replicated write data
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_WriteData;
    case (mem_size)
      2'b00: begin
        st_be    = 4'b0001 << mem_ALUOUT[1:0];
        st_wdata = {4{mem_WriteData[7:0]}};
      end
      2'b01: begin
        st_be    = mem_ALUOUT[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_WriteData[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = mem_WriteData;
      end
    endcase
  end

  // Load formatting: pick the little-endian lane and extend it
  always_comb begin
    ld_data = dmem.dmem_rdata;
    case (size_q)
      2'b00: begin
        logic [7:0] b;
        b       = dmem.dmem_rdata[8*off_q +: 8];
        ld_data = {{24{sext_q & b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h       = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        ld_data = {{16{sext_q & h[15]}}, h};
      end
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (dmem.dmem_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; buserr is a one-cycle pulse by default
  always_comb begin
    cnt_d    = cnt_q;
    size_d   = size_q;
    sext_d   = sext_q;
    off_d    = off_q;
    memout_d = memout_q;
    buserr_d = 1'b0;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = 1'b1;
          we_d    = mem_MemWrite;
          addr_d  = {mem_ALUOUT[31:2], 2'b00};
          be_d    = mem_MemWrite ? st_be : 4'b1111;
          wdata_d = st_wdata;
          size_d  = mem_size;
          sext_d  = mem_signext;
          off_d   = mem_ALUOUT[1:0];
          cnt_d   = 16'd0;
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) memout_d = ld_data;
        end else if (timeout) begin
          req_d    = 1'b0;
          buserr_d = 1'b1;
          if (!we_q) memout_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and bus registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      size_q   <= '0;
      sext_q   <= 1'b0;
      off_q    <= '0;
      memout_q <= '0;
      buserr_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      off_q    <= off_d;
      memout_q <= memout_d;
      buserr_q <= buserr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected load results are queued when an
// operation is driven and popped when its DONE cycle is reached.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [1:0]  mem_size;
  logic        mem_signext;
  logic [31:0] mem_ALUOUT;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_MEMOUT;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_buserr;

  mem_access_if dif ();

  mem_access #(.WAIT_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .mem_size     (mem_size),
    .mem_signext  (mem_signext),
    .mem_ALUOUT   (mem_ALUOUT),
    .mem_WriteData(mem_WriteData),
    .mem_MEMOUT   (mem_MEMOUT),
    .mem_stall    (mem_stall),
    .mem_misalign (mem_misalign),
    .mem_buserr   (mem_buserr),
    .dmem         (dif)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [31:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete aligned access with nwait ack-less BUSY cycles. Called at a
  // negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic op(input string tag, input logic rd, input logic wr,
                    input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] rdv, input int nwait,
                    input logic [31:0] e_addr, input logic [3:0] e_be,
                    input logic [31:0] e_wd, input logic [31:0] e_out);
    int stalls;
    logic [31:0] exp;
    sb.push_back(e_out);
    mem_MemRead = rd; mem_MemWrite = wr; mem_size = sz; mem_signext = sx;
    mem_ALUOUT = a; mem_WriteData = wd;
    #1;
    stalls = (mem_stall === 1'b1) ? 1 : 0;
    chk({tag, ".misalign"}, {31'd0, mem_misalign}, 32'd0);
    @(negedge clk);
    chk({tag, ".req"},  {31'd0, dif.dmem_req}, 32'd1);
    chk({tag, ".we"},   {31'd0, dif.dmem_we}, {31'd0, wr});
    chk({tag, ".addr"}, dif.dmem_addr, e_addr);
    chk({tag, ".be"},   {28'd0, dif.dmem_be}, {28'd0, e_be});
    if (wr) chk({tag, ".wdata"}, dif.dmem_wdata, e_wd);
    for (int i = 0; i < nwait; i++) begin
      if (mem_stall === 1'b1) stalls++;
      @(negedge clk);
      chk({tag, ".req_hold"},  {31'd0, dif.dmem_req}, 32'd1);
      chk({tag, ".addr_hold"}, dif.dmem_addr, e_addr);
    end
    if (mem_stall === 1'b1) stalls++;
    dif.dmem_ack = 1'b1; dif.dmem_rdata = rdv;
    @(negedge clk);
    dif.dmem_ack = 1'b0; dif.dmem_rdata = $urandom;
    exp = sb.pop_front();
    $display("%s: MEMOUT=%h expected=%h stall_cycles=%0d", tag, mem_MEMOUT, exp, stalls);
    chk({tag, ".done_stall"}, {31'd0, mem_stall}, 32'd0);
    chk({tag, ".done_req"},   {31'd0, dif.dmem_req}, 32'd0);
    chk({tag, ".buserr"},     {31'd0, mem_buserr}, 32'd0);
    chk({tag, ".memout"},     mem_MEMOUT, exp);
    chk({tag, ".stalls"},     32'(stalls), 32'(nwait + 2));
    @(negedge clk);
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
  endtask

  initial begin
    int n;
    int t0;
    int t1;
    rst = 1'b1;
    mem_MemRead = 0; mem_MemWrite = 0; mem_size = 0; mem_signext = 0;
    mem_ALUOUT = 0; mem_WriteData = 0;
    dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("rst.memout", mem_MEMOUT, 32'd0);
    chk("rst.stall",  {31'd0, mem_stall}, 32'd0);
    chk("rst.req",    {31'd0, dif.dmem_req}, 32'd0);
    chk("rst.addr",   dif.dmem_addr, 32'd0);
    chk("rst.be",     {28'd0, dif.dmem_be}, 32'd0);
    chk("rst.wdata",  dif.dmem_wdata, 32'd0);
    chk("rst.buserr", {31'd0, mem_buserr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    $display("reset: MEMOUT=%h stall=%b req=%b", mem_MEMOUT, mem_stall, dif.dmem_req);

    op("lw100",  1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h8899AABB, 0, 32'h100, 4'b1111, 32'h0, 32'h8899AABB);
    op("lb3s",   1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h8899AABB, 0, 32'h100, 4'b1111, 32'h0, 32'hFFFFFF88);
    op("lbu3",   1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h8899AABB, 1, 32'h100, 4'b1111, 32'h0, 32'h00000088);
    op("lh2s",   1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h8899AABB, 0, 32'h100, 4'b1111, 32'h0, 32'hFFFF8899);
    op("sb203",  0, 1, 2'b00, 0, 32'h203, 32'h0000005A, 32'h0, 0, 32'h200, 4'b1000, 32'h5A5A5A5A, 32'hFFFF8899);
    op("sh202",  0, 1, 2'b01, 0, 32'h202, 32'hABCD1234, 32'h0, 1, 32'h200, 4'b1100, 32'h12341234, 32'hFFFF8899);
    op("sb201",  0, 1, 2'b00, 0, 32'h201, 32'h000000C3, 32'h0, 0, 32'h200, 4'b0010, 32'hC3C3C3C3, 32'hFFFF8899);

    // Misaligned word load: flagged combinationally, never issued
    mem_MemRead = 1; mem_size = 2'b10; mem_ALUOUT = 32'h102;
    #1;
    chk("mis.flag",  {31'd0, mem_misalign}, 32'd1);
    chk("mis.stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    chk("mis.req",    {31'd0, dif.dmem_req}, 32'd0);
    chk("mis.memout", mem_MEMOUT, 32'hFFFF8899);
    $display("misalign: flag=%b req=%b MEMOUT=%h", mem_misalign, dif.dmem_req, mem_MEMOUT);
    mem_MemRead = 0;
    @(negedge clk);

    // Timeout: no ack ever, WAIT_MAX = 4
    mem_MemRead = 1; mem_size = 2'b10; mem_ALUOUT = 32'h180;
    @(negedge clk);
    n = 0;
    while (dif.dmem_req === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("tmo.req_cycles", 32'(n), 32'd4);
    chk("tmo.buserr",     {31'd0, mem_buserr}, 32'd1);
    chk("tmo.memout",     mem_MEMOUT, 32'd0);
    chk("tmo.stall",      {31'd0, mem_stall}, 32'd0);
    $display("timeout: req_cycles=%0d buserr=%b MEMOUT=%h", n, mem_buserr, mem_MEMOUT);
    @(negedge clk);
    mem_MemRead = 0;
    chk("tmo.buserr_clr", {31'd0, mem_buserr}, 32'd0);

    // Back-to-back loads with two wait cycles each
    t0 = cycle;
    op("b2b0", 1, 0, 2'b10, 0, 32'h300, 32'h0, 32'hCAFEF00D, 2, 32'h300, 4'b1111, 32'h0, 32'hCAFEF00D);
    t1 = cycle;
    op("b2b1", 1, 0, 2'b01, 0, 32'h306, 32'h0, 32'h0BADBEEF, 2, 32'h304, 4'b1111, 32'h0, 32'h00000BAD);
    chk("b2b.spacing", 32'(t1 - t0), 32'd5);
    $display("back-to-back: spacing=%0d", t1 - t0);

    // Reset in the middle of BUSY, then a late ack
    mem_MemRead = 1; mem_size = 2'b10; mem_ALUOUT = 32'h400;
    @(negedge clk);
    chk("rbusy.req_before", {31'd0, dif.dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rbusy.req_async", {31'd0, dif.dmem_req}, 32'd0);
    chk("rbusy.stall",     {31'd0, mem_stall}, 32'd0);
    chk("rbusy.memout",    mem_MEMOUT, 32'd0);
    mem_MemRead = 0;
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dif.dmem_ack = 1'b0;
    chk("rbusy.late_memout", mem_MEMOUT, 32'd0);
    chk("rbusy.late_req",    {31'd0, dif.dmem_req}, 32'd0);
    chk("rbusy.late_buserr", {31'd0, mem_buserr}, 32'd0);
    $display("reset-in-busy: req=%b MEMOUT=%h", dif.dmem_req, mem_MEMOUT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
